// File: rtl/ps2_receiver_pkg.sv
// Shared constants, FSM state type and frame helpers for the PS/2 receive path.
package ps2_receiver_pkg;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;

  // Bit-count value held while waiting for the stop bit (start counts as bit 1).
  localparam logic [3:0] StopBitIdx = 4'd10;

  typedef enum logic [0:0] {
    StIdle,
    StReceive
  } ps2_state_e;

  // True when the data byte plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Two-flop synchroniser, FILTER_LEN-sample debounce and falling-edge pulse for one PS/2 line.
module ps2_input_filter
  import ps2_receiver_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_low,
  input  logic pin_i,
  output logic fall_o
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flip;

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      sync_q  <= 2'b11;
      level_q <= HIGH;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample that agrees with the current level restarts the run count.
  always_comb begin
    sync_d  = {sync_q[0], pin_i};
    level_d = level_q;
    cnt_d   = '0;
    flip    = NO;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        flip    = YES;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign fall_o = flip & level_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver delivering scan codes over a valid/ready handshake.
module ps2_receiver
  import ps2_receiver_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       ps2_clk_pin,
  input  logic       ps2_data_pin,
  output logic       frame_error,
  input  logic       scan_code_ready,
  output logic       scan_code_valid,
  output logic [7:0] scan_code
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e     state_q, state_d;
  logic [1:0]     data_sync_q;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [8:0]     shift_q, shift_d;
  logic [ToW-1:0] timeout_q, timeout_d;
  logic [7:0]     code_q, code_d;
  logic           valid_q, valid_d;
  logic           error_q, error_d;

  logic       clk_fall;
  logic       data_bit;
  logic [9:0] frame_w;
  logic       frame_done;
  logic       frame_good;
  logic       timeout_hit;

  ps2_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset_low(reset_low),
    .pin_i    (ps2_clk_pin),
    .fall_o   (clk_fall)
  );

  assign data_bit = data_sync_q[1];
  assign frame_w  = {data_bit, shift_q};

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (clk_fall && data_bit == LOW) state_d = StReceive;
      StReceive: if (frame_done || timeout_hit) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    frame_done  = NO;
    timeout_hit = NO;
    if (state_q == StReceive) begin
      frame_done  = clk_fall && (bit_cnt_q == StopBitIdx);
      timeout_hit = !clk_fall && (timeout_q == ToW'(TIMEOUT_CYCLES - 1));
    end
    frame_good = frame_done && (frame_w[9] == HIGH) && odd_parity_ok(frame_w[8:0]);
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      data_sync_q <= 2'b11;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      timeout_q   <= '0;
      code_q      <= 8'h00;
      valid_q     <= NO;
      error_q     <= NO;
    end else begin
      data_sync_q <= {data_sync_q[0], ps2_data_pin};
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      timeout_q   <= timeout_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    timeout_d = '0;
    unique case (state_q)
      StIdle: begin
        if (clk_fall && data_bit == LOW) begin
          bit_cnt_d = 4'd1;
          shift_d   = '0;
        end
      end
      StReceive: begin
        if (clk_fall) begin
          shift_d   = {data_bit, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else begin
          timeout_d = timeout_q + ToW'(1);
        end
        if (frame_done || timeout_hit) begin
          bit_cnt_d = '0;
          timeout_d = '0;
        end
      end
      default: bit_cnt_d = '0;
    endcase
  end

  // A transfer in the completing cycle frees the slot, so that is not an overflow.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    error_d = error_q;
    if (valid_q && scan_code_ready) valid_d = NO;
    if (frame_done) begin
      if (!frame_good) begin
        error_d = YES;
      end else if (!valid_q || scan_code_ready) begin
        code_d  = frame_w[7:0];
        valid_d = YES;
      end else begin
        error_d = YES;
      end
    end
    if (timeout_hit) error_d = YES;
  end

  assign frame_error     = error_q;
  assign scan_code_valid = valid_q;
  assign scan_code       = code_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: good/bad frames, overflow, timeout, glitches, async reset.
module tb_ps2_receiver;

  localparam int unsigned FilterLen     = 8;
  localparam int unsigned TimeoutCycles = 1000;
  localparam int          Half          = 20;

  logic       clk = 1'b0;
  logic       reset_low;
  logic       ps2_clk_pin;
  logic       ps2_data_pin;
  logic       scan_code_ready;
  logic       frame_error;
  logic       scan_code_valid;
  logic [7:0] scan_code;

  int tests_run    = 0;
  int tests_failed = 0;

  int         accept_cnt   = 0;
  int         valid_cycles = 0;
  logic [7:0] last_code    = 8'h00;

  always #5 clk = ~clk;

  ps2_receiver #(
    .FILTER_LEN    (FilterLen),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk            (clk),
    .reset_low      (reset_low),
    .ps2_clk_pin    (ps2_clk_pin),
    .ps2_data_pin   (ps2_data_pin),
    .frame_error    (frame_error),
    .scan_code_ready(scan_code_ready),
    .scan_code_valid(scan_code_valid),
    .scan_code      (scan_code)
  );

  // Handshake monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (reset_low) begin
      if (scan_code_valid) valid_cycles <= valid_cycles + 1;
      if (scan_code_valid && scan_code_ready) begin
        accept_cnt <= accept_cnt + 1;
        last_code  <= scan_code;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data_pin = bits[i];
      wait_cycles(Half);
      ps2_clk_pin = 1'b0;
      wait_cycles(Half);
      ps2_clk_pin = 1'b1;
    end
    wait_cycles(Half);
    ps2_data_pin = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    logic [10:0] bits;
    bits = {stop, (~^d) ^ par_flip, d, 1'b0};
    send_bits(bits, 11);
    wait_cycles(30);
  endtask

  task automatic sync_reset();
    reset_low    = 1'b0;
    ps2_clk_pin  = 1'b1;
    ps2_data_pin = 1'b1;
    wait_cycles(3);
    reset_low = 1'b1;
    wait_cycles(5);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int v0;

    reset_low       = 1'b0;
    ps2_clk_pin     = 1'b1;
    ps2_data_pin    = 1'b1;
    scan_code_ready = 1'b1;
    wait_cycles(4);
    check_eq("rst_err", frame_error, 0);
    check_eq("rst_valid", scan_code_valid, 0);
    check_eq("rst_code", scan_code, 8'h00);
    reset_low = 1'b1;
    wait_cycles(5);

    // Good 8'h1C with ready held high: one-cycle valid pulse.
    a0 = accept_cnt;
    v0 = valid_cycles;
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("good_accepts", accept_cnt - a0, 1);
    check_eq("good_code", last_code, 8'h1C);
    check_eq("good_pulse", valid_cycles - v0, 1);
    check_eq("good_err", frame_error, 0);
    check_eq("good_valid_low", scan_code_valid, 0);

    // Clock glitches shorter than the filter length, with data low.
    a0 = accept_cnt;
    ps2_data_pin = 1'b0;
    for (int k = 1; k <= FilterLen - 2; k++) begin
      ps2_clk_pin = 1'b0;
      wait_cycles(k);
      ps2_clk_pin = 1'b1;
      wait_cycles(12);
    end
    ps2_data_pin = 1'b1;
    wait_cycles(10);
    check_eq("glitch_accepts", accept_cnt - a0, 0);
    check_eq("glitch_err", frame_error, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("post_glitch_accepts", accept_cnt - a0, 1);
    check_eq("post_glitch_code", last_code, 8'h1C);
    check_eq("post_glitch_err", frame_error, 0);

    // Bad parity.
    a0 = accept_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    check_eq("par_accepts", accept_cnt - a0, 0);
    check_eq("par_err", frame_error, 1);
    wait_cycles(50);
    check_eq("par_err_sticky", frame_error, 1);
    sync_reset();
    check_eq("par_err_cleared", frame_error, 0);

    // Bad stop bit.
    a0 = accept_cnt;
    send_frame(8'h29, 1'b0, 1'b0);
    check_eq("stop_accepts", accept_cnt - a0, 0);
    check_eq("stop_valid", scan_code_valid, 0);
    check_eq("stop_err", frame_error, 1);
    sync_reset();

    // Overflow: ready low, two frames; first byte kept.
    scan_code_ready = 1'b0;
    send_frame(8'hF0, 1'b0, 1'b1);
    check_eq("ovf_first_valid", scan_code_valid, 1);
    check_eq("ovf_first_code", scan_code, 8'hF0);
    check_eq("ovf_first_err", frame_error, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("ovf_valid_held", scan_code_valid, 1);
    check_eq("ovf_code_held", scan_code, 8'hF0);
    check_eq("ovf_err", frame_error, 1);
    a0 = accept_cnt;
    scan_code_ready = 1'b1;
    wait_cycles(1);
    check_eq("ovf_drop_valid", scan_code_valid, 0);
    check_eq("ovf_drop_accept", accept_cnt - a0, 1);
    check_eq("ovf_drop_code", last_code, 8'hF0);
    sync_reset();

    // Timeout on a partial frame, then a complete frame.
    a0 = accept_cnt;
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    check_eq("to_err_early", frame_error, 0);
    wait_cycles(TimeoutCycles + 200);
    check_eq("to_err", frame_error, 1);
    check_eq("to_accepts", accept_cnt - a0, 0);
    send_frame(8'h29, 1'b0, 1'b1);
    check_eq("to_next_accepts", accept_cnt - a0, 1);
    check_eq("to_next_code", last_code, 8'h29);
    check_eq("to_next_err", frame_error, 1);

    // Async reset mid-frame while the error flag is set.
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 3);
    @(posedge clk);
    #3;
    reset_low = 1'b0;
    #1;
    check_eq("arst_mid_err", frame_error, 0);
    check_eq("arst_mid_valid", scan_code_valid, 0);
    check_eq("arst_mid_code", scan_code, 8'h00);
    wait_cycles(3);
    reset_low = 1'b1;
    wait_cycles(5);

    // Async reset while holding a byte.
    scan_code_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("hold_valid", scan_code_valid, 1);
    check_eq("hold_code", scan_code, 8'h1C);
    @(posedge clk);
    #3;
    reset_low = 1'b0;
    #1;
    check_eq("arst_valid", scan_code_valid, 0);
    check_eq("arst_code", scan_code, 8'h00);
    check_eq("arst_err", frame_error, 0);
    wait_cycles(3);
    reset_low = 1'b1;
    wait_cycles(5);

    scan_code_ready = 1'b1;
    a0 = accept_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("after_rst_accepts", accept_cnt - a0, 1);
    check_eq("after_rst_code", last_code, 8'h1C);
    check_eq("after_rst_err", frame_error, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
